imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-fetch controller that sequences the synchronous instruction memory (2-cycle address-to-data latency, no enable) on behalf of the IF stage. Owns the fetch PC, issues one word address per cycle, tracks in-flight reads, buffers returned instructions in a small FIFO, and presents them to IF/ID over a valid/ready handshake. Handles redirects (branch/jump/trap) by discarding stale reads and flags out-of-range or misaligned fetches as faults.

## Interface
- XLEN, 32, PC and instruction width
- ADDR_WIDTH, 10, IMEM word-address width
- RESET_PC, 32'h0000_0000, PC after reset (word-aligned)
- BUF_DEPTH, 4, output FIFO entries (power of 2, ≥3)

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- imem_addr  out  ADDR_WIDTH  word address to IMEM (pc[ADDR_WIDTH+1:2])
- imem_data  in  XLEN  IMEM read data, 2 cycles after imem_addr
- imem_addr_valid  in  1  IMEM range flag, aligned with imem_data
- redirect_valid  in  1  load new PC this cycle
- redirect_pc  in  XLEN  redirect target (byte address)
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  IF/ID accepts head
- inst  out  XLEN  instruction (NOP 32'h0000_0013 on fault)
- inst_pc  out  XLEN  byte PC of inst
- inst_fault  out  1  fetch fault (out of range or misaligned)

## Operation
- States: RUN (issuing), HALT (fault emitted, issuing stopped). Reset → RUN.
- Issue address: redirect_valid ? redirect_pc : pc. Issue in cycle t when state=RUN (or redirect_valid) and fifo_count + inflight < BUF_DEPTH; on issue pc ← issued_pc + 4.
- In-flight tracking: 2-stage shift pipe of {valid, pc, epoch, oor}; oor = issued_pc[XLEN-1:ADDR_WIDTH+2] != 0. imem_addr is driven every cycle; non-issue cycles carry valid=0.
- Return: stage-2 entry with valid=1 and epoch == current epoch is pushed as {imem_data, pc, fault=0}; if oor or !imem_addr_valid, push {NOP, pc, fault=1} and state → HALT. Stale-epoch entries dropped.
- Redirect: epoch toggles, FIFO flushed, in-flight entries become stale, state → RUN. redirect_pc[1:0] != 0 → no IMEM issue; push {NOP, redirect_pc, fault=1} next cycle; state → HALT.
- HALT: no issue; remaining in-flight/buffered entries still drained; leave only via redirect.
- Handshake: pop when inst_valid && inst_ready; inst/inst_pc/inst_fault stable while inst_valid && !inst_ready.

## Timing
- Reset outputs: inst_valid=0, inst=32'h0000_0013, inst_pc=0, inst_fault=0, imem_addr=RESET_PC[ADDR_WIDTH+1:2]; FIFO empty, pipe invalid, epoch=0, pc=RESET_PC.
- Cycle 0 = first cycle with rst low: RESET_PC issued; data at IMEM cycle 2; pushed end of cycle 2; inst_valid high cycle 3.
- Steady state with inst_ready=1: one instruction per cycle, no bubbles (BUF_DEPTH ≥ 3 covers latency).
- Redirect in cycle t: target issued cycle t; its inst_valid earliest t+3; nothing from the old epoch is presented from cycle t+1 on.
- Simultaneous redirect + pop: pop counts, FIFO flushed anyway. Redirect + fault return same cycle: redirect wins, fault dropped. Push + pop same cycle on full FIFO: allowed, count unchanged.
- Credit rule guarantees no overflow; overflow is an assertion failure.
- rst mid-operation: all state returns to reset values next cycle; in-flight data discarded.

## Structure
- Package fetch_pkg: NOP_INST = 32'h0000_0013, fetch_entry_t {inst, pc, fault}, fetch_state_e {RUN, HALT}, inflight_t {valid, pc, epoch, oor}.
- Sub-module fetch_fifo (parameterised depth, entry type fetch_entry_t, push/pop/flush, count, full/empty); rest in imem_fetch_ctrl.

## Test plan
- Reset, RESET_PC=0, IMEM holds 00100093, 00200113, 002081B3, inst_ready=1 → inst_valid first in cycle 3, pcs 0,4,8 on consecutive cycles with those words.
- inst_ready low cycles 4–10 → at most BUF_DEPTH entries held, head stable, no loss/duplication on release; pcs strictly sequential.
- redirect_valid at cycle 6 with redirect_pc=0x40 → no old-epoch instruction after cycle 6, inst_pc=0x40 at cycle 9, then 0x44.
- redirect_pc=0x42 → single entry {NOP, 0x42, fault=1}, then inst_valid stays 0 until a new redirect to 0x80 resumes fetch.
- PC runs to 0x1000 (ADDR_WIDTH=10) → entry {NOP, 0x1000, fault=1}, HALT; entries before 0x1000 delivered normally.
- rst asserted mid-stream with full FIFO → next cycle inst_valid=0; refetch from RESET_PC, first inst_valid 3 cycles after rst drops.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] inst;
        logic [FETCH_XLEN-1:0] pc;
        logic                  fault;
    } fetch_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [FETCH_XLEN-1:0] pc;
        logic                  epoch;
        logic                  oor;
    } inflight_t;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : imem_fetch_ctrl_if
// Brief     : IMEM, redirect and IF/ID handshake signals of the fetch controller.
// Revision  : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [XLEN-1:0]       imem_data;
    logic                  imem_addr_valid;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [XLEN-1:0]       inst;
    logic [XLEN-1:0]       inst_pc;
    logic                  inst_fault;

    modport master (
        output imem_addr,
        input  imem_data,
        input  imem_addr_valid,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output inst_fault
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output imem_addr_valid,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  inst_fault
    );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small FIFO of fetched entries with flush; count/full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [PW:0]    r_wr_ptr;
    logic [PW:0]    r_rd_ptr;
    logic           w_do_push;
    logic           w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        o_count   = r_wr_ptr - r_rd_ptr;
        o_full    = (o_count == (PW+1)'(DEPTH));
        o_empty   = (o_count == '0);
        o_head    = r_mem[r_rd_ptr[PW-1:0]];
        w_do_pop  = i_pop && !o_empty && !i_flush;
        w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            assert (!(i_push && o_full && !i_pop));
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : Fetch PC owner; sequences 2-cycle IMEM reads into an output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              ADDR_WIDTH = 10,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              BUF_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    imem_fetch_ctrl_if.master  bus
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [XLEN-1:0]    r_pc;
    logic               r_epoch;
    inflight_t          r_s1;
    inflight_t          r_s2;
    logic               r_mis_valid;
    logic [XLEN-1:0]    r_mis_pc;

    logic [XLEN-1:0]    w_issue_pc;
    logic               w_mis;
    logic               w_next_epoch;
    logic               w_live1;
    logic               w_live2;
    logic [CNT_W:0]     w_occ;
    logic               w_issue;
    logic               w_ret_live;
    logic               w_ret_fault;
    logic               w_push;
    logic               w_pop;
    fetch_entry_t       w_push_data;
    fetch_entry_t       w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;

    always_comb begin
        w_issue_pc   = bus.redirect_valid ? bus.redirect_pc : r_pc;
        w_mis        = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        w_next_epoch = bus.redirect_valid ? ~r_epoch : r_epoch;
        w_live1      = r_s1.valid && (r_s1.epoch == r_epoch);
        w_live2      = r_s2.valid && (r_s2.epoch == r_epoch);
        // A redirect flushes the FIFO and stales every in-flight read, so it always has credit.
        w_occ        = bus.redirect_valid ? '0
                     : ({1'b0, w_count} + (CNT_W+1)'(w_live1) + (CNT_W+1)'(w_live2));
        w_issue      = ((r_state == RUN) || bus.redirect_valid) && !w_mis
                     && (w_occ < (CNT_W+1)'(BUF_DEPTH));
        w_ret_live   = w_live2 && !bus.redirect_valid && (r_state == RUN);
        w_ret_fault  = r_s2.oor || !bus.imem_addr_valid;
        w_push       = w_ret_live || (r_mis_valid && !bus.redirect_valid);
        w_pop        = !w_empty && bus.inst_ready;

        if (r_mis_valid) begin
            w_push_data = '{inst: NOP_INST, pc: r_mis_pc, fault: 1'b1};
        end else if (w_ret_fault) begin
            w_push_data = '{inst: NOP_INST, pc: r_s2.pc, fault: 1'b1};
        end else begin
            w_push_data = '{inst: bus.imem_data, pc: r_s2.pc, fault: 1'b0};
        end

        bus.imem_addr  = w_issue_pc[ADDR_WIDTH+1:2];
        bus.inst_valid = !w_empty;
        bus.inst       = w_empty ? NOP_INST : w_head.inst;
        bus.inst_pc    = w_empty ? '0 : w_head.pc;
        bus.inst_fault = !w_empty && w_head.fault;
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.redirect_valid) begin
            w_state_next = w_mis ? HALT : RUN;
        end else if (w_ret_live && w_ret_fault) begin
            w_state_next = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_epoch     <= 1'b0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_mis_valid <= 1'b0;
            r_mis_pc    <= '0;
        end else begin
            r_epoch <= w_next_epoch;
            if (w_issue) begin
                r_pc <= w_issue_pc + XLEN'(4);
            end else if (bus.redirect_valid) begin
                r_pc <= bus.redirect_pc;
            end
            r_s1 <= '{valid: w_issue,
                      pc:    w_issue_pc,
                      epoch: w_next_epoch,
                      oor:   |w_issue_pc[XLEN-1:ADDR_WIDTH+2]};
            r_s2        <= r_s1;
            r_mis_valid <= w_mis;
            r_mis_pc    <= bus.redirect_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    logic w_unused;
    assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Brief    : Directed bench for imem_fetch_ctrl with a 2-cycle IMEM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;
    import fetch_pkg::*;

    localparam int XLEN  = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();

    imem_fetch_ctrl #(
        .XLEN       (XLEN),
        .ADDR_WIDTH (AW),
        .RESET_PC   (32'h0000_0000),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0]   mem [1024];
    logic [AW-1:0] a1;
    int            bad_word = -1;
    int            cyc = 0;
    int            n_run = 0;
    int            n_fail = 0;

    always @(posedge clk) begin
        a1                  <= bus.imem_addr;
        bus.imem_data       <= mem[a1];
        bus.imem_addr_valid <= (int'(a1) != bad_word);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_until(input int k);
        while (cyc < k) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input logic [31:0] pc, input logic fault);
        logic [31:0] w;
        string       t;
        w = fault ? NOP_INST : mem[pc[11:2]];
        t = $sformatf("c%0d_pc%0h", cyc, pc);
        chk({t, ".valid"}, 32'(bus.inst_valid), 32'd1);
        chk({t, ".pc"},    bus.inst_pc, pc);
        chk({t, ".inst"},  bus.inst, w);
        chk({t, ".fault"}, 32'(bus.inst_fault), 32'(fault));
    endtask

    task automatic chk_idle();
        chk($sformatf("c%0d.idle", cyc), 32'(bus.inst_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".valid"}, 32'(bus.inst_valid), 32'd0);
        chk({tag, ".inst"},  bus.inst, NOP_INST);
        chk({tag, ".pc"},    bus.inst_pc, 32'd0);
        chk({tag, ".fault"}, 32'(bus.inst_fault), 32'd0);
        chk({tag, ".addr"},  32'(bus.imem_addr), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        cyc = 0;
    endtask

    // Redirect asserted for exactly the current cycle.
    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        #1;
        if (pc[1:0] == 2'b00) chk($sformatf("c%0d.redir_addr", cyc), 32'(bus.imem_addr), 32'(pc[11:2]));
        @(posedge clk);
        #1;
        cyc++;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 | 32'(i);
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0020_0113;
        mem[2] = 32'h0020_81B3;

        // Startup latency, streaming, redirects, misaligned and out-of-range faults.
        do_reset();
        chk("c0.addr", 32'(bus.imem_addr), 32'd0);
        chk_idle();
        tick(); chk("c1.addr", 32'(bus.imem_addr), 32'd1); chk_idle();
        tick(); chk_idle();
        tick(); chk_inst(32'h0, 1'b0);
        tick(); chk_inst(32'h4, 1'b0);
        tick(); chk_inst(32'h8, 1'b0);
        tick(); chk_inst(32'hC, 1'b0);
        redirect(32'h40);
        chk_idle();
        tick(); chk_idle();
        tick(); chk_inst(32'h40, 1'b0);
        tick(); chk_inst(32'h44, 1'b0);
        tick(); chk_inst(32'h48, 1'b0);
        tick();
        redirect(32'h42);
        chk_idle();
        tick(); chk_inst(32'h42, 1'b1);
        tick(); chk_idle();
        go_until(18); chk_idle();
        go_until(20);
        redirect(32'h80);
        tick(); tick(); chk_inst(32'h80, 1'b0);
        tick(); chk_inst(32'h84, 1'b0);
        tick();
        redirect(32'hFF0);
        tick(); tick(); chk_inst(32'hFF0, 1'b0);
        tick(); chk_inst(32'hFF4, 1'b0);
        tick(); chk_inst(32'hFF8, 1'b0);
        tick(); chk_inst(32'hFFC, 1'b0);
        tick(); chk_inst(32'h1000, 1'b1);
        tick(); chk_idle();
        go_until(36); chk_idle();
        bad_word = 32'h80;
        tick();
        redirect(32'h200);
        tick(); tick(); chk_inst(32'h200, 1'b1);
        tick(); chk_idle();
        go_until(43); chk_idle();
        bad_word = -1;

        // Backpressure: head held stable, then released with no loss or bubbles.
        do_reset();
        go_until(3); chk_inst(32'h0, 1'b0);
        tick();
        bus.inst_ready = 1'b0;
        for (int k = 4; k <= 10; k++) begin
            chk_inst(32'h4, 1'b0);
            if (k == 8) chk("c8.stall_addr", 32'(bus.imem_addr), 32'd5);
            tick();
        end
        bus.inst_ready = 1'b1;
        for (int k = 11; k <= 18; k++) begin
            chk_inst(32'(4 + 4 * (k - 11)), 1'b0);
            tick();
        end

        // Mid-stream reset with a full FIFO.
        bus.inst_ready = 1'b0;
        go_until(25);
        chk("c25.full_valid", 32'(bus.inst_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        bus.inst_ready = 1'b1;
        cyc = 0;
        chk_idle();
        tick(); chk_idle();
        tick(); chk_idle();
        tick(); chk_inst(32'h0, 1'b0);
        tick(); chk_inst(32'h4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
